// File: rtl/pmod_panel_ctrl.sv
// PMOD front-panel controller: debounced buttons drive a BCD up/down counter
// with auto-count, shown on a scanned seven-segment display and an LED bank.
module pmod_panel_ctrl #(
    parameter int unsigned N_DIGIT   = 2,
    parameter int unsigned LED_N     = 8,
    parameter int unsigned DEB_CYC   = 1_000_000,
    parameter int unsigned SCAN_CYC  = 50_000,
    parameter int unsigned AUTO_CYC  = 25_000_000,
    parameter int unsigned STEP_CYC  = 5_000_000,
    parameter int unsigned BLINK_CYC = 12_500_000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [3:0]         i_button,
    input  logic [3:0]         i_switch,
    output logic [LED_N-1:0]   o_led,
    output logic [6:0]         o_nixieTube,
    output logic [N_DIGIT-1:0] o_sel
);
    localparam int unsigned DEB_W   = $clog2(DEB_CYC + 1);
    localparam int unsigned SCAN_W  = $clog2(SCAN_CYC + 1);
    localparam int unsigned AUTO_W  = $clog2(AUTO_CYC + 1);
    localparam int unsigned STEP_W  = $clog2(STEP_CYC + 1);
    localparam int unsigned BLINK_W = $clog2(BLINK_CYC + 1);
    localparam int unsigned IDX_W   = (N_DIGIT > 1) ? $clog2(N_DIGIT) : 1;
    localparam int unsigned POS_W   = (LED_N > 1) ? $clog2(LED_N) : 1;
    localparam int unsigned PACK_W  = (LED_N > 4 * N_DIGIT) ? LED_N : 4 * N_DIGIT;

    logic [3:0]              btn_s1, btn_s2, sw_s1, sw_s2;
    logic [3:0]              deb_state, press;
    logic [3:0][DEB_W-1:0]   deb_cnt;
    logic [N_DIGIT-1:0][3:0] digit, digit_inc, digit_dec;
    logic                    auto_on, auto_tick, up, down;
    logic [AUTO_W-1:0]       auto_cnt;
    logic [SCAN_W-1:0]       scan_cnt;
    logic [IDX_W-1:0]        scan_idx;
    logic [STEP_W-1:0]       step_cnt;
    logic [POS_W-1:0]        led_pos;
    logic [BLINK_W-1:0]      blink_cnt;
    logic                    blink_on;
    logic [PACK_W-1:0]       bcd_ext;
    logic [LED_N-1:0]        pattern;
    logic                    carry, borrow;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'h3F;
            4'd1: seg7 = 7'h06;
            4'd2: seg7 = 7'h5B;
            4'd3: seg7 = 7'h4F;
            4'd4: seg7 = 7'h66;
            4'd5: seg7 = 7'h6D;
            4'd6: seg7 = 7'h7D;
            4'd7: seg7 = 7'h07;
            4'd8: seg7 = 7'h7F;
            4'd9: seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            btn_s1 <= '1;
            btn_s2 <= '1;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= i_button;
            btn_s2 <= btn_s1;
            sw_s1  <= i_switch;
            sw_s2  <= sw_s1;
        end
    end

    // deb_state is 1 when pressed; a pulse fires only on the release->press flip
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            deb_state <= '0;
            deb_cnt   <= '0;
            press     <= '0;
        end else begin
            press <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                if (!btn_s2[i] == deb_state[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_W'(DEB_CYC - 1)) begin
                    deb_cnt[i]   <= '0;
                    deb_state[i] <= !btn_s2[i];
                    press[i]     <= !btn_s2[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        digit_inc = digit;
        digit_dec = digit;
        carry     = 1'b1;
        borrow    = 1'b1;
        for (int unsigned i = 0; i < N_DIGIT; i++) begin
            if (carry) begin
                if (digit[i] == 4'd9) begin
                    digit_inc[i] = '0;
                end else begin
                    digit_inc[i] = digit[i] + 4'd1;
                    carry        = 1'b0;
                end
            end
            if (borrow) begin
                if (digit[i] == 4'd0) begin
                    digit_dec[i] = 4'd9;
                end else begin
                    digit_dec[i] = digit[i] - 4'd1;
                    borrow       = 1'b0;
                end
            end
        end
    end

    assign auto_tick = auto_on && (auto_cnt == AUTO_W'(AUTO_CYC - 1));
    assign up        = press[0] || auto_tick;
    assign down      = press[1];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            digit    <= '0;
            auto_on  <= 1'b0;
            auto_cnt <= '0;
        end else begin
            if (press[3])
                digit <= '0;
            else if (up && !down)
                digit <= digit_inc;
            else if (down && !up)
                digit <= digit_dec;

            if (press[2])
                auto_on <= !auto_on;

            if (!auto_on || press[3] || auto_tick)
                auto_cnt <= '0;
            else
                auto_cnt <= auto_cnt + 1'b1;
        end
    end

    // o_sel and segments are both registered from the same index, so they switch together
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            scan_cnt    <= '0;
            scan_idx    <= '0;
            o_sel       <= N_DIGIT'(1);
            o_nixieTube <= '0;
        end else begin
            if (scan_cnt == SCAN_W'(SCAN_CYC - 1)) begin
                scan_cnt <= '0;
                scan_idx <= (scan_idx == IDX_W'(N_DIGIT - 1)) ? '0 : scan_idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            o_sel       <= N_DIGIT'(1) << scan_idx;
            o_nixieTube <= seg7(digit[scan_idx]);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            step_cnt  <= '0;
            led_pos   <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else begin
            if (step_cnt == STEP_W'(STEP_CYC - 1)) begin
                step_cnt <= '0;
                led_pos  <= (led_pos == POS_W'(LED_N - 1)) ? '0 : led_pos + 1'b1;
            end else begin
                step_cnt <= step_cnt + 1'b1;
            end
            if (blink_cnt == BLINK_W'(BLINK_CYC - 1)) begin
                blink_cnt <= '0;
                blink_on  <= !blink_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        bcd_ext                = '0;
        bcd_ext[4*N_DIGIT-1:0] = digit;
        case (sw_s2[1:0])
            2'd0:    pattern = '0;
            2'd1:    pattern = '1;
            2'd2:    pattern = LED_N'(1) << led_pos;
            default: pattern = bcd_ext[LED_N-1:0];
        endcase
        if (sw_s2[2])
            pattern = ~pattern;
        if (sw_s2[3] && !blink_on)
            pattern = '0;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            o_led <= '0;
        else
            o_led <= pattern;
    end

endmodule

// File: tb/tb_pmod_panel_ctrl.sv
// Randomised self-checking bench for pmod_panel_ctrl; the counter is modelled
// as an integer modulo 10^N_DIGIT and LED timing from elapsed-cycle arithmetic.
module tb_pmod_panel_ctrl;
    localparam int N_DIGIT = 2;
    localparam int LED_N   = 8;
    localparam int DEB     = 4;
    localparam int SCAN    = 3;
    localparam int AUTO    = 10;
    localparam int STEP    = 2;
    localparam int BLINK   = 5;
    localparam int MODV    = 100;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [3:0]         btn = 4'hF;
    logic [3:0]         sw = 4'h0;
    logic [LED_N-1:0]   led;
    logic [6:0]         nixie;
    logic [N_DIGIT-1:0] sel;

    int checks = 0;
    int errors = 0;
    int ref_count = 0;
    int cyc = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    pmod_panel_ctrl #(
        .N_DIGIT(N_DIGIT), .LED_N(LED_N), .DEB_CYC(DEB), .SCAN_CYC(SCAN),
        .AUTO_CYC(AUTO), .STEP_CYC(STEP), .BLINK_CYC(BLINK)
    ) dut (
        .i_clk(clk), .i_rst(rst_n), .i_button(btn), .i_switch(sw),
        .o_led(led), .o_nixieTube(nixie), .o_sel(sel)
    );

    always #5 clk = ~clk;

    // edges elapsed since the last reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [LED_N-1:0] bcd_of(input int v);
        logic [LED_N-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < N_DIGIT; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int digit_of(input int v, input int d);
        int x;
        x = v;
        for (int i = 0; i < d; i++) x = x / 10;
        return x % 10;
    endfunction

    task automatic press(input logic [3:0] mask, input int hold);
        @(negedge clk);
        btn = ~mask;
        repeat (hold) @(negedge clk);
        btn = 4'hF;
        repeat (DEB + 4) @(negedge clk);
    endtask

    task automatic wait_sel(input int d, output bit ok);
        logic [N_DIGIT-1:0] want;
        want = '0;
        want[d] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 4 * SCAN * N_DIGIT && !ok; i++) begin
            @(posedge clk);
            #1;
            if (sel === want) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        btn = 4'hF;
        sw = 4'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (led !== '0) begin errors++; $display("FAIL reset_led: got %h expected 00", led); end
        checks++;
        if (nixie !== 7'h00) begin errors++; $display("FAIL reset_nixie: got %h expected 00", nixie); end
        checks++;
        if (sel !== 2'b01) begin errors++; $display("FAIL reset_sel: got %b expected 01", sel); end
        rst_n = 1'b1;
        ref_count = 0;
        @(posedge clk);
        #1;
        checks++;
        if (nixie !== 7'h3F) begin errors++; $display("FAIL first_nixie: got %h expected 3F", nixie); end
    endtask

    task automatic test_scan;
        int k, idx;
        logic [N_DIGIT-1:0] want;
        @(negedge clk);
        sw = 4'b0011;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            k = cyc;
            idx = ((k - 1) / SCAN) % N_DIGIT;
            want = '0;
            want[idx] = 1'b1;
            checks++;
            if (sel !== want) begin errors++; $display("FAIL scan_sel k=%0d: got %b expected %b", k, sel, want); end
            checks++;
            if (nixie !== seg_tab[digit_of(ref_count, idx)]) begin
                errors++;
                $display("FAIL scan_seg k=%0d: got %h expected %h", k, nixie, seg_tab[digit_of(ref_count, idx)]);
            end
        end
    endtask

    task automatic test_press_latency;
        int p, first;
        bit ok;
        first = -1;
        @(negedge clk);
        p = cyc;
        btn[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (first < 0 && led === bcd_of(1)) first = cyc - p;
        end
        @(negedge clk);
        btn = 4'hF;
        repeat (DEB + 6) @(negedge clk);
        ref_count = 1;
        checks++;
        if (first != DEB + 4) begin errors++; $display("FAIL press_latency: got %0d expected %0d", first, DEB + 4); end
        checks++;
        if (led !== bcd_of(1)) begin errors++; $display("FAIL held_single_pulse: got %h expected %h", led, bcd_of(1)); end
        wait_sel(0, ok);
        checks++;
        if (!ok || nixie !== 7'h06) begin errors++; $display("FAIL digit0_after_inc: got %h sel_found=%0d expected 06", nixie, ok); end
        press(4'b0001, 3);
        checks++;
        if (led !== bcd_of(1)) begin errors++; $display("FAIL glitch_ignored: got %h expected %h", led, bcd_of(1)); end
    endtask

    task automatic test_random_counter;
        int op, b;
        bit ok;
        for (int n = 0; n < 20; n++) begin
            op = $urandom_range(0, 2);
            if (op == 0) begin
                press(4'b0001, $urandom_range(DEB, DEB + 6));
                ref_count = (ref_count + 1) % MODV;
            end else if (op == 1) begin
                press(4'b0010, $urandom_range(DEB, DEB + 6));
                ref_count = (ref_count + MODV - 1) % MODV;
            end else begin
                b = $urandom_range(0, 1);
                press(4'(1 << b), $urandom_range(1, DEB - 1));
            end
            checks++;
            if (led !== bcd_of(ref_count)) begin
                errors++;
                $display("FAIL rand_count n=%0d op=%0d: got %h expected %h", n, op, led, bcd_of(ref_count));
            end
        end
        for (int d = 0; d < N_DIGIT; d++) begin
            wait_sel(d, ok);
            checks++;
            if (!ok || nixie !== seg_tab[digit_of(ref_count, d)]) begin
                errors++;
                $display("FAIL rand_display d=%0d: got %h expected %h", d, nixie, seg_tab[digit_of(ref_count, d)]);
            end
        end
    endtask

    task automatic test_wrap;
        bit ok;
        press(4'b1000, DEB + 1);
        ref_count = 0;
        checks++;
        if (led !== bcd_of(0)) begin errors++; $display("FAIL clear: got %h expected 00", led); end
        press(4'b0010, DEB + 2);
        ref_count = MODV - 1;
        checks++;
        if (led !== bcd_of(MODV - 1)) begin errors++; $display("FAIL wrap_down: got %h expected %h", led, bcd_of(MODV - 1)); end
        for (int d = 0; d < N_DIGIT; d++) begin
            wait_sel(d, ok);
            checks++;
            if (!ok || nixie !== 7'h6F) begin errors++; $display("FAIL wrap_down_seg d=%0d: got %h expected 6F", d, nixie); end
        end
        press(4'b0001, DEB + 2);
        ref_count = 0;
        checks++;
        if (led !== bcd_of(0)) begin errors++; $display("FAIL wrap_up: got %h expected 00", led); end
    endtask

    task automatic test_simultaneous;
        int n;
        n = $urandom_range(1, 5);
        for (int i = 0; i < n; i++) press(4'b0001, DEB);
        ref_count = (ref_count + n) % MODV;
        checks++;
        if (led !== bcd_of(ref_count)) begin errors++; $display("FAIL sim_setup: got %h expected %h", led, bcd_of(ref_count)); end
        press(4'b0011, DEB + 1);
        checks++;
        if (led !== bcd_of(ref_count)) begin errors++; $display("FAIL inc_dec_same: got %h expected %h", led, bcd_of(ref_count)); end
        press(4'b1001, DEB + 1);
        ref_count = 0;
        checks++;
        if (led !== bcd_of(0)) begin errors++; $display("FAIL clear_inc_same: got %h expected 00", led); end
    endtask

    task automatic test_auto;
        int p1, d;
        d = $urandom_range(35, 45);
        @(negedge clk);
        btn[2] = 1'b0;
        p1 = cyc;
        repeat (DEB + 4) @(negedge clk);
        btn = 4'hF;
        while (cyc < p1 + d) @(negedge clk);
        btn[2] = 1'b0;
        repeat (DEB + 4) @(negedge clk);
        btn = 4'hF;
        repeat (2 * DEB + 8) @(negedge clk);
        ref_count = (ref_count + d / AUTO) % MODV;
        checks++;
        if (led !== bcd_of(ref_count)) begin
            errors++;
            $display("FAIL auto_count d=%0d: got %h expected %h", d, led, bcd_of(ref_count));
        end
        repeat (3 * AUTO) @(negedge clk);
        checks++;
        if (led !== bcd_of(ref_count)) begin errors++; $display("FAIL auto_stopped: got %h expected %h", led, bcd_of(ref_count)); end
    endtask

    task automatic test_led_patterns;
        int k;
        logic [3:0] s;
        logic [LED_N-1:0] pat;
        for (int w = 0; w < 8; w++) begin
            if (w == 0) s = 4'b0010;
            else if (w == 1) s = 4'b0110;
            else if (w == 2) s = 4'b1010;
            else s = 4'($urandom_range(0, 15));
            @(negedge clk);
            sw = s;
            repeat (4) @(negedge clk);
            for (int i = 0; i < 20; i++) begin
                @(posedge clk);
                #1;
                k = cyc;
                case (s[1:0])
                    2'd0: pat = '0;
                    2'd1: pat = '1;
                    2'd2: pat = LED_N'(1) << (((k - 1) / STEP) % LED_N);
                    default: pat = bcd_of(ref_count);
                endcase
                if (s[2]) pat = ~pat;
                if (s[3] && (((k - 1) / BLINK) % 2 == 1)) pat = '0;
                checks++;
                if (led !== pat) begin
                    errors++;
                    $display("FAIL led_pattern sw=%b k=%0d: got %h expected %h", s, k, led, pat);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int p;
        bit ok;
        @(negedge clk);
        sw = 4'b0011;
        press(4'b1000, DEB);
        ref_count = 0;
        for (int i = 0; i < 42; i++) press(4'b0001, DEB);
        ref_count = 42;
        checks++;
        if (led !== bcd_of(42)) begin errors++; $display("FAIL reach_42: got %h expected 42", led); end
        @(negedge clk);
        btn[2] = 1'b0;
        p = cyc;
        while (cyc < p + DEB + 5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        btn = 4'hF;
        #1;
        checks++;
        if (led !== '0) begin errors++; $display("FAIL midreset_led: got %h expected 00", led); end
        checks++;
        if (nixie !== 7'h00) begin errors++; $display("FAIL midreset_nixie: got %h expected 00", nixie); end
        checks++;
        if (sel !== 2'b01) begin errors++; $display("FAIL midreset_sel: got %b expected 01", sel); end
        @(negedge clk);
        rst_n = 1'b1;
        ref_count = 0;
        repeat (3 * AUTO) @(negedge clk);
        checks++;
        if (led !== bcd_of(0)) begin errors++; $display("FAIL midreset_count_auto_off: got %h expected 00", led); end
        wait_sel(1, ok);
        checks++;
        if (!ok || nixie !== 7'h3F) begin errors++; $display("FAIL midreset_tens: got %h expected 3F", nixie); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_press_latency();
        test_random_counter();
        test_wrap();
        test_simultaneous();
        test_auto();
        test_led_patterns();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
